wait_state_memory: RTL
======================

// Module: wait_state_memory
// PURPOSE
//  Parametrised, clocked successor to the MU0 combinational memory.
//  Single-port RAM behind a memRq/readNotWrite request with a memAck completion handshake.
//  Programmable wait states emulate slow memory for the MU0 datapath/control FSM.
//  Sits between MU0 control unit (requester) and the program/data store.
// PARAMETERS
//  DATA_W       16        data word width
//  ADDR_W       16        address bus width
//  DEPTH        256       implemented words (<= 2**ADDR_W); addr >= DEPTH is out of range
//  WAIT_CYCLES  1         extra cycles between request capture and memAck (0 allowed)
//  IDLE_VALUE   {DATA_W{1'b1}}  dataOut value whenever memRq=0
// PORTS
//  clk           in   1       rising-edge clock
//  reset         in   1       async, active-high
//  memRq         in   1       request; level held by requester until memAck
//  readNotWrite  in   1       1=read, 0=write; sampled at request capture
//  addr          in   ADDR_W  word address; sampled at request capture
//  dataIn        in   DATA_W  write data; sampled at request capture
//  dataOut       out  DATA_W  read data (registered) or IDLE_VALUE
//  memAck        out  1       one-cycle completion pulse
//  memBusy       out  1       1 while a request is in flight (WAIT or ACK state)
//  memErr        out  1       out-of-range flag (MEM_RANGE_CHECK_EN only)
// BEHAVIOUR
//  - Reset: state=IDLE, memAck=0, memBusy=0, memErr=0, read register=IDLE_VALUE. RAM contents not cleared.
//  - FSM IDLE -> WAIT -> ACK -> IDLE.
//  - IDLE: memRq=1 latches addr/dataIn/readNotWrite and loads the wait counter with WAIT_CYCLES.
//    Next state is WAIT, or ACK directly if WAIT_CYCLES=0.
//  - WAIT: counter decrements each cycle; moves to ACK when counter reaches 1 (exactly WAIT_CYCLES cycles in WAIT).
//  - ACK: memAck=1 for exactly one cycle.
//    Write: RAM[addr] <= dataIn at the end of the ACK cycle.
//    Read: read register <= RAM[addr], visible on dataOut in the ACK cycle.
//  - Latency from memRq rising to memAck=1: WAIT_CYCLES+1 clocks.
//  - After ACK: returns to IDLE. If memRq is still 1 in IDLE, a new request is captured (back-to-back; min period WAIT_CYCLES+2).
//  - dataOut = memRq ? read register : IDLE_VALUE (combinational mux). It holds the last read data while memRq stays high.
//  - memRq dropped during WAIT: abort, return to IDLE next cycle, no RAM write, no memAck.
//  - Inputs changing during WAIT/ACK are ignored; the latched copies are used.
//  - Read-after-write to the same address in consecutive requests returns the new data.
//  - Reset asserted mid-operation: immediate return to reset values. A pending write is discarded; earlier completed writes are kept.
//  - Address index uses addr[clog2(DEPTH)-1:0]. Without range check, out-of-range addresses alias modulo DEPTH.
// CONFIGURATION
//  MEM_RANGE_CHECK_EN defined:
//    - memErr port exists. An access with latched addr >= DEPTH still completes with memAck.
//    - Writes are suppressed; reads return IDLE_VALUE.
//    - memErr=1 during the ACK cycle only.
//  Not defined: memErr port absent; aliasing as above.
// STRUCTURE
//  - mem_pkg: state enum (IDLE, WAIT, ACK) and the default IDLE_VALUE constant.
//  - Sub-module mem_array: plain synchronous single-port RAM (DATA_W x DEPTH, we, addr, wdata, rdata), no reset.
//  - Top level: FSM, wait counter, request latches, output mux.
// TESTING
//  1. WAIT_CYCLES=1: write 0x00AA @0, then read @0 -> memAck 2 clks after memRq; dataOut=0x00AA.
//  2. Write 0x0055 @31, read @31 -> 0x0055; drop memRq -> dataOut=0xFFFF the same cycle.
//  3. WAIT_CYCLES=0, memRq held high over 4 reads -> memAck every 2nd cycle, correct data each.
//  4. Write 0x1234 @5, memRq dropped in WAIT -> no memAck; read @5 returns the old value.
//  5. Reset pulsed in WAIT during a write -> outputs return to reset values, RAM[addr] unchanged, next request OK.
//  6. MEM_RANGE_CHECK_EN, DEPTH=256, read @0x0100 -> memAck=1, memErr=1, dataOut=0xFFFF; write @0x0100 leaves @0 unchanged.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the wait-state memory.
// Optional range checking is enabled with the MEM_RANGE_CHECK_EN macro.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    // Idle data is all-ones at any width; replicate this bit to build it.
    localparam logic IDLE_FILL = 1'b1;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_ADDR_W = 16;
    localparam int DEFAULT_DEPTH  = 256;

endpackage

// File: rtl/mem_array.sv
// Plain synchronous single-port RAM with registered read and no reset,
// so it maps onto block RAM.
module mem_array #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Read-before-write: a read in the same cycle as a write sees the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/wait_state_memory.sv
// Clocked MU0 memory: memRq/readNotWrite request, programmable wait states, memAck pulse.
// Define MEM_RANGE_CHECK_EN to add memErr and block accesses at addr >= DEPTH.
module wait_state_memory
    import mem_pkg::*;
#(
    parameter int                DATA_W      = DEFAULT_DATA_W,
    parameter int                ADDR_W      = DEFAULT_ADDR_W,
    parameter int                DEPTH       = DEFAULT_DEPTH,
    parameter int                WAIT_CYCLES = 1,
    parameter logic [DATA_W-1:0] IDLE_VALUE  = {DATA_W{IDLE_FILL}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memRq,
    input  logic              readNotWrite,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] dataIn,
    output logic [DATA_W-1:0] dataOut,
    output logic              memAck,
    output logic              memBusy
`ifdef MEM_RANGE_CHECK_EN
    ,
    output logic              memErr
`endif
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic              rnw_q, rnw_d;
    logic              err_q, err_d;

    logic              addr_oob;
    logic              unused_addr_bits;
    logic              ram_we;
    logic [IDX_W-1:0]  ram_addr;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] ack_rdata;

    // Only the low IDX_W address bits index the RAM; the rest alias or feed the range check.
    assign unused_addr_bits = ^addr;

`ifdef MEM_RANGE_CHECK_EN
    assign addr_oob = ({1'b0, addr} >= (ADDR_W + 1)'(DEPTH));
`else
    assign addr_oob = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rnw_d   = rnw_q;
        err_d   = err_q;
        rd_d    = rd_q;
        case (state_q)
            IDLE: begin
                if (memRq) begin
                    addr_d  = addr[IDX_W-1:0];
                    wdata_d = dataIn;
                    rnw_d   = readNotWrite;
                    err_d   = addr_oob;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES == 0) ? ACK : WAIT;
                end
            end
            WAIT: begin
                if (!memRq) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACK: begin
                state_d = IDLE;
                if (rnw_q) begin
                    rd_d = ack_rdata;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rnw_q   <= 1'b1;
            err_q   <= 1'b0;
            rd_q    <= IDLE_VALUE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rnw_q   <= rnw_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
        end
    end

    // The RAM read must land on the edge that enters ACK: with zero wait states that
    // edge is the capture edge itself, so IDLE presents the live address.
    assign ram_addr  = (state_q == IDLE) ? addr[IDX_W-1:0] : addr_q;
    assign ram_we    = (state_q == ACK) && !rnw_q && !err_q;
    assign ack_rdata = err_q ? IDLE_VALUE : ram_rdata;

    mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem_array (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    always_comb begin
        dataOut = rd_q;
        if (!memRq) begin
            dataOut = IDLE_VALUE;
        end else if ((state_q == ACK) && rnw_q) begin
            dataOut = ack_rdata;
        end
    end

    assign memAck  = (state_q == ACK);
    assign memBusy = (state_q != IDLE);
`ifdef MEM_RANGE_CHECK_EN
    assign memErr  = (state_q == ACK) && err_q;
`endif

endmodule
